// File: rtl/spectrum_bar_scheduler_if.sv
// Write handshake between the FFT result writer and the bar scheduler.
// The writer holds valid/addr/data until it sees ready.
interface spectrum_bar_scheduler_if;
  logic       wr_valid;
  logic [5:0] wr_addr;
  logic [8:0] wr_data;
  logic       wr_ready;

  modport master (
    output wr_valid, wr_addr, wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    output wr_ready
  );
endinterface

// File: rtl/spectrum_bar_scheduler.sv
// Arbitrates the spectrum RAM between FFT writes and VGA bar readout,
// prefetching one bin per bar ahead of the beam and drawing bars.
module spectrum_bar_scheduler #(
  parameter int          NUM_BARS  = 64,
  parameter int          BAR_WIDTH = 10,
  parameter int          H_ACTIVE  = 640,
  parameter int          H_TOTAL   = 800,
  parameter int          V_ACTIVE  = 480,
  parameter int          V_TOTAL   = 525,
  parameter logic [11:0] BAR_COLOR = 12'h0F0,
  parameter bit          WRITE_DURING_ACTIVE = 1'b0
) (
  input  logic        pixel_clk,
  input  logic        reset,
  spectrum_bar_scheduler_if.slave wr,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  input  logic        video_on_in,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  output logic        frame_done,
  output logic [5:0]  ram_addr,
  output logic        ram_we,
  output logic [8:0]  ram_wdata,
  input  logic [8:0]  ram_rdata,
  output logic        h_sync_out,
  output logic        v_sync_out,
  output logic [11:0] rgb
);

  localparam logic [9:0] L_BW   = 10'(BAR_WIDTH);
  localparam logic [9:0] L_BW1  = 10'(BAR_WIDTH - 1);
  localparam logic [9:0] L_BW2  = 10'(BAR_WIDTH - 2);
  localparam logic [9:0] L_LAST = 10'(H_ACTIVE - BAR_WIDTH);
  localparam logic [9:0] L_HT2  = 10'(H_TOTAL - 2);
  localparam logic [9:0] L_VA   = 10'(V_ACTIVE);
  localparam logic [9:0] L_VA1  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] L_VT1  = 10'(V_TOTAL - 1);
  localparam logic [8:0] L_HMAX = 9'(V_ACTIVE);
  localparam logic [5:0] L_CLR  = 6'(NUM_BARS - 1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_WAIT_SYNC,
    S_BLANK,
    S_DISPLAY
  } state_t;

  state_t      r_state;
  logic [5:0]  r_clr_cnt;
  logic [8:0]  r_bar_h;
  logic        r_fetch_d;
  logic [11:0] r_rgb;
  logic        r_hs;
  logic        r_vs;

  logic [9:0]  w_col;
  logic [9:0]  w_bar;
  logic [5:0]  w_bar_next;
  logic [8:0]  w_clip;
  logic [9:0]  w_thresh;
  logic        w_vstart;
  logic        w_row_fetch;
  logic        w_bar_fetch;
  logic        w_clear;
  logic        w_fetch;
  logic        w_live;
  logic        w_win;
  logic        w_ready;
  logic        w_wr_hs;
  logic        w_lit;

  assign w_col      = pixel_x % L_BW;
  assign w_bar      = pixel_x / L_BW;
  assign w_bar_next = 6'(w_bar + 10'd1);
  assign w_clip     = (ram_rdata > L_HMAX) ?
                      L_HMAX : ram_rdata;
  assign w_thresh   = L_VA - {1'b0, r_bar_h};

  assign w_vstart = (pixel_x == 10'd0) &&
                    (pixel_y == L_VA);

  // Row fetch loads bin 0 two cycles before column 0.
  assign w_row_fetch = (pixel_x == L_HT2) &&
                       ((pixel_y < L_VA1) ||
                        (pixel_y == L_VT1));
  assign w_bar_fetch = (pixel_y < L_VA) &&
                       (pixel_x < L_LAST) &&
                       (w_col == L_BW2);

  assign w_clear = (r_state == S_CLEAR);
  assign w_fetch = ~w_clear &
                   (w_row_fetch | w_bar_fetch);
  assign w_live  = (r_state == S_WAIT_SYNC) ||
                   (r_state == S_DISPLAY);
  assign w_win   = (r_state == S_BLANK) ||
                   (w_live && w_vstart);

  assign w_ready = ~w_fetch &
                   (w_win |
                    (WRITE_DURING_ACTIVE &&
                     (r_state == S_DISPLAY)));
  assign w_wr_hs = wr.wr_valid & w_ready;

  assign w_lit = video_on_in &&
                 (w_col != L_BW1) &&
                 (pixel_y >= w_thresh);

  assign wr.wr_ready = w_ready;
  assign frame_done  = w_live & w_vstart;
  assign h_sync_out  = r_hs;
  assign v_sync_out  = r_vs;
  assign rgb         = r_rgb;

  // Sources are mutually exclusive by construction of w_ready.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = 6'd0;
    ram_wdata = 9'd0;
    unique case (1'b1)
      w_clear: begin
        ram_we   = ~reset;
        ram_addr = r_clr_cnt;
      end
      w_fetch: begin
        ram_addr = w_row_fetch ?
                   6'd0 : w_bar_next;
      end
      w_wr_hs: begin
        ram_we    = 1'b1;
        ram_addr  = wr.wr_addr;
        ram_wdata = wr.wr_data;
      end
      default: begin
        ram_we = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= 6'd0;
      r_bar_h   <= 9'd0;
      r_fetch_d <= 1'b0;
      r_rgb     <= 12'd0;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
    end else begin
      r_hs      <= h_sync_in;
      r_vs      <= v_sync_in;
      r_rgb     <= w_lit ? BAR_COLOR : 12'd0;
      r_fetch_d <= w_fetch;
      if (r_fetch_d)
        r_bar_h <= w_clip;
      unique case (r_state)
        S_CLEAR: begin
          r_bar_h   <= 9'd0;
          r_clr_cnt <= r_clr_cnt + 6'd1;
          if (r_clr_cnt == L_CLR)
            r_state <= S_WAIT_SYNC;
        end
        S_WAIT_SYNC: begin
          if (w_vstart)
            r_state <= S_BLANK;
        end
        S_BLANK: begin
          if ((pixel_y == L_VT1) &&
              (pixel_x == L_HT2))
            r_state <= S_DISPLAY;
        end
        S_DISPLAY: begin
          if (w_vstart)
            r_state <= S_BLANK;
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_spectrum_bar_scheduler.sv
// Bench for spectrum_bar_scheduler: handshake vector table, scoreboard
// of registered pixel/sync outputs, clear, reset and write-window cases.
module tb_spectrum_bar_scheduler;

  localparam logic [11:0] COLOR = 12'h0F0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hs_in, vs_in, von;
  logic [9:0]  px, py;
  logic        fix_sync = 1'b0;

  spectrum_bar_scheduler_if wr0();
  spectrum_bar_scheduler_if wr1();

  logic        fd0, fd1, we0, we1;
  logic [5:0]  ra0, ra1;
  logic [8:0]  wd0, wd1, rd0, rd1;
  logic        hso0, vso0, hso1, vso1;
  logic [11:0] rgb0, rgb1;
  logic [8:0]  mem0 [64];
  logic [8:0]  mem1 [64];

  int total = 0;
  int bad = 0;
  int mbin [64];

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    int x; int y;
    bit wv; int wa; int wd;
    bit rdy; bit we; int addr; bit fd;
  } vec_t;
  vec_t tbl [11];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we0) mem0[ra0] <= wd0;
    rd0 <= mem0[ra0];
  end

  always @(posedge clk) begin
    if (we1) mem1[ra1] <= wd1;
    rd1 <= mem1[ra1];
  end

  spectrum_bar_scheduler #(
    .WRITE_DURING_ACTIVE(1'b0)
  ) u_dut0 (
    .pixel_clk(clk), .reset(reset), .wr(wr0),
    .h_sync_in(hs_in), .v_sync_in(vs_in),
    .video_on_in(von),
    .pixel_x(px), .pixel_y(py),
    .frame_done(fd0),
    .ram_addr(ra0), .ram_we(we0),
    .ram_wdata(wd0), .ram_rdata(rd0),
    .h_sync_out(hso0), .v_sync_out(vso0),
    .rgb(rgb0)
  );

  spectrum_bar_scheduler #(
    .WRITE_DURING_ACTIVE(1'b1)
  ) u_dut1 (
    .pixel_clk(clk), .reset(reset), .wr(wr1),
    .h_sync_in(hs_in), .v_sync_in(vs_in),
    .video_on_in(von),
    .pixel_x(px), .pixel_y(py),
    .frame_done(fd1),
    .ram_addr(ra1), .ram_we(we1),
    .ram_wdata(wd1), .ram_rdata(rd1),
    .h_sync_out(hso1), .v_sync_out(vso1),
    .rgb(rgb1)
  );

  task automatic chk(input string name,
                     input int act,
                     input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               name, act, exp);
    end
  endtask

  function automatic logic [11:0] exp_rgb();
    int h;
    int idx;
    if (reset || !von) return 12'h000;
    if (int'(px) >= 640) return 12'h000;
    if (int'(px) % 10 == 9) return 12'h000;
    idx = int'(px) / 10;
    h = mbin[idx];
    if (h > 480) h = 480;
    if (int'(py) >= 480 - h) return COLOR;
    return 12'h000;
  endfunction

  task automatic apply();
    if (!fix_sync) begin
      hs_in = 1'($urandom_range(0, 1));
      vs_in = 1'($urandom_range(0, 1));
    end
    #1;
  endtask

  task automatic tick();
    exp_t e;
    e.rgb = exp_rgb();
    e.hs  = reset ? 1'b1 : hs_in;
    e.vs  = reset ? 1'b1 : vs_in;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("rgb", rgb0, e.rgb);
      chk("hsync", hso0, e.hs);
      chk("vsync", vso0, e.vs);
    end
  endtask

  task automatic clear_check();
    for (int c = 0; c < 64; c++) begin
      px = (c % 2 == 1) ? 10'd8 : 10'd5;
      py = 10'd100;
      von = 1'b0;
      wr0.wr_valid = 1'b1;
      wr0.wr_addr = 6'(c ^ 21);
      wr0.wr_data = 9'h1AA;
      apply();
      chk("clr_we", we0, 1);
      chk("clr_addr", ra0, c);
      chk("clr_data", wd0, 0);
      chk("clr_rdy", wr0.wr_ready, 0);
      tick();
    end
    wr0.wr_valid = 1'b0;
    px = 10'd5;
    apply();
    chk("clr_len", we0, 0);
    chk("wait_rdy", wr0.wr_ready, 0);
    tick();
    for (int i = 0; i < 64; i++) mbin[i] = 0;
  endtask

  task automatic line(input int y,
                      input int xmax,
                      input bit hold);
    int prev;
    prev = (y == 0) ? 524 : y - 1;
    von = 1'b0;
    px = 10'd798;
    py = 10'(prev);
    apply();
    chk("row_fetch_addr", ra0, 0);
    chk("row_fetch_we", we0, 0);
    if (hold) chk("hold_rdy", wr0.wr_ready, 0);
    tick();
    px = 10'd799;
    apply();
    if (hold) chk("hold_rdy", wr0.wr_ready, 0);
    if (hold) chk("hold_we", we0, 0);
    tick();
    for (int x = 0; x <= xmax; x++) begin
      px = 10'(x);
      py = 10'(y);
      von = 1'b1;
      apply();
      if (x % 10 == 8 && x < 630)
        chk("bar_fetch_addr", ra0, x / 10 + 1);
      if (hold) begin
        chk("hold_rdy", wr0.wr_ready, 0);
        chk("hold_we", we0, 0);
      end
      tick();
    end
    von = 1'b0;
  endtask

  task automatic set1(input int x, input int y,
                      input bit wv, input int wa,
                      input int wd);
    px = 10'(x);
    py = 10'(y);
    wr1.wr_valid = wv;
    wr1.wr_addr = 6'(wa);
    wr1.wr_data = 9'(wd);
    apply();
  endtask

  initial begin
    tbl[0]  = '{5,   100, 1, 4, 44,  0, 0, -1, 0};
    tbl[1]  = '{8,   100, 1, 4, 44,  0, 0, 1,  0};
    tbl[2]  = '{798, 524, 0, 0, 0,   0, 0, 0,  0};
    tbl[3]  = '{0,   480, 1, 3, 100, 1, 1, 3,  1};
    tbl[4]  = '{1,   480, 1, 5, 500, 1, 1, 5,  0};
    tbl[5]  = '{2,   481, 0, 0, 0,   1, 0, -1, 0};
    tbl[6]  = '{798, 524, 1, 7, 9,   0, 0, 0,  0};
    tbl[7]  = '{799, 524, 1, 7, 9,   0, 0, -1, 0};
    tbl[8]  = '{18,  10,  1, 7, 9,   0, 0, 2,  0};
    tbl[9]  = '{19,  10,  1, 7, 9,   0, 0, -1, 0};
    tbl[10] = '{0,   480, 1, 7, 9,   1, 1, 7,  1};

    for (int i = 0; i < 64; i++) mbin[i] = 0;
    px = 10'd5;
    py = 10'd100;
    von = 1'b0;
    hs_in = 1'b0;
    vs_in = 1'b0;
    wr0.wr_valid = 1'b0;
    wr0.wr_addr = 6'd0;
    wr0.wr_data = 9'd0;
    wr1.wr_valid = 1'b0;
    wr1.wr_addr = 6'd0;
    wr1.wr_data = 9'd0;

    apply();
    chk("rst_we", we0, 0);
    chk("rst_addr", ra0, 0);
    chk("rst_rdy", wr0.wr_ready, 0);
    chk("rst_fd", fd0, 0);
    tick();
    tick();
    chk("rst_rgb", rgb0, 0);
    chk("rst_hs", hso0, 1);
    chk("rst_vs", vso0, 1);
    reset = 1'b0;

    clear_check();

    for (int i = 0; i < 11; i++) begin
      px = 10'(tbl[i].x);
      py = 10'(tbl[i].y);
      von = 1'b0;
      wr0.wr_valid = tbl[i].wv;
      wr0.wr_addr = 6'(tbl[i].wa);
      wr0.wr_data = 9'(tbl[i].wd);
      apply();
      chk("tbl_rdy", wr0.wr_ready, int'(tbl[i].rdy));
      chk("tbl_we", we0, int'(tbl[i].we));
      if (tbl[i].addr >= 0)
        chk("tbl_addr", ra0, tbl[i].addr);
      if (tbl[i].we)
        chk("tbl_wdata", wd0, tbl[i].wd);
      chk("tbl_fd", fd0, int'(tbl[i].fd));
      if (tbl[i].wv && tbl[i].rdy)
        mbin[tbl[i].wa] = tbl[i].wd;
      tick();
    end
    wr0.wr_valid = 1'b0;

    line(0, 639, 1'b0);
    wr0.wr_valid = 1'b1;
    wr0.wr_addr = 6'd9;
    wr0.wr_data = 9'd200;
    line(100, 639, 1'b1);
    line(379, 639, 1'b1);
    line(380, 639, 1'b1);
    line(479, 639, 1'b1);
    px = 10'd0;
    py = 10'd480;
    apply();
    chk("late_rdy", wr0.wr_ready, 1);
    chk("late_we", we0, 1);
    chk("late_addr", ra0, 9);
    chk("late_wdata", wd0, 200);
    chk("late_fd", fd0, 1);
    chk("fd1", fd1, 1);
    mbin[9] = 200;
    tick();
    wr0.wr_valid = 1'b0;

    line(200, 55, 1'b0);
    fix_sync = 1'b1;
    hs_in = 1'b0;
    vs_in = 1'b0;
    px = 10'd56;
    von = 1'b1;
    apply();
    tick();
    chk("pre_rst_rgb", rgb0, COLOR);
    reset = 1'b1;
    #1;
    chk("async_rgb", rgb0, 0);
    chk("async_hs", hso0, 1);
    chk("async_vs", vso0, 1);
    chk("async_rgb1", rgb1, 0);
    chk("async_hs1", hso1, 1);
    chk("async_vs1", vso1, 1);
    sbq.delete();
    fix_sync = 1'b0;
    von = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply();
      chk("rst2_we", we0, 0);
      chk("rst2_rdy", wr0.wr_ready, 0);
      tick();
    end
    reset = 1'b0;
    clear_check();

    px = 10'd0;
    py = 10'd480;
    apply();
    chk("vstart_fd", fd0, 1);
    chk("vstart_rdy", wr0.wr_ready, 1);
    tick();
    line(0, 639, 1'b0);
    line(379, 639, 1'b0);
    line(479, 639, 1'b0);

    set1(17, 10, 0, 0, 0);
    chk("wda_idle_rdy", wr1.wr_ready, 1);
    chk("wda_idle_we", we1, 0);
    chk("nowda_rdy", wr0.wr_ready, 0);
    tick();
    set1(18, 10, 1, 11, 33);
    chk("wda_fetch_rdy", wr1.wr_ready, 0);
    chk("wda_fetch_we", we1, 0);
    chk("wda_fetch_addr", ra1, 2);
    tick();
    set1(19, 10, 1, 11, 33);
    chk("wda_acc_rdy", wr1.wr_ready, 1);
    chk("wda_acc_we", we1, 1);
    chk("wda_acc_addr", ra1, 11);
    chk("wda_acc_data", wd1, 33);
    tick();
    set1(20, 10, 0, 0, 0);
    chk("wda_after_rdy", wr1.wr_ready, 1);
    chk("wda_after_we", we1, 0);
    tick();
    set1(798, 9, 1, 12, 44);
    chk("wda_row_rdy", wr1.wr_ready, 0);
    chk("wda_row_addr", ra1, 0);
    chk("wda_row_we", we1, 0);
    tick();
    set1(799, 9, 1, 12, 44);
    chk("wda_row2_rdy", wr1.wr_ready, 1);
    chk("wda_row2_we", we1, 1);
    chk("wda_row2_addr", ra1, 12);
    chk("wda_row2_data", wd1, 44);
    tick();
    wr1.wr_valid = 1'b0;

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/spectrum_bar_scheduler.md
Name: spectrum_bar_scheduler

Overview:
- Sequences access to the single-port spectrum magnitude RAM (NUM_BARS bins) between the FFT result writer and the VGA readout.
- Sits between vga_controller (timing/coordinates in) and the VGA pins (delayed syncs + RGB out).
- Prefetches one bin per bar ahead of the beam and renders vertical bars.
- Gates FFT writes to vertical blanking so frames are tear-free; clears the RAM after reset.

Parameters:
NUM_BARS, 64, number of bins/bars; ram address width is 6.
BAR_WIDTH, 10, pixels per bar; NUM_BARS*BAR_WIDTH must equal H_ACTIVE.
H_ACTIVE, 640, visible pixels per line.
H_TOTAL, 800, pixel_x wraps at H_TOTAL-1.
V_ACTIVE, 480, visible lines.
V_TOTAL, 525, pixel_y wraps at V_TOTAL-1.
BAR_COLOR, 12'h0F0, RGB444 colour of lit bar pixels.
WRITE_DURING_ACTIVE, 0, 1 = writes also accepted in non-fetch cycles of the display window.

Ports:
pixel_clk  in  1  pixel clock; all logic on its rising edge.
reset  in  1  asynchronous, active-high reset.
h_sync_in  in  1  from vga_controller.
v_sync_in  in  1  from vga_controller.
video_on_in  in  1  from vga_controller.
pixel_x  in  10  current column, 0..H_TOTAL-1.
pixel_y  in  10  current line, 0..V_TOTAL-1.
wr_valid  in  1  FFT writer has a bin.
wr_addr  in  6  bin index.
wr_data  in  9  bin magnitude.
wr_ready  out  1  write accepted this cycle when wr_valid & wr_ready.
frame_done  out  1  one-cycle pulse at blanking-window start.
ram_addr  out  6  RAM address.
ram_we  out  1  RAM write enable.
ram_wdata  out  9  RAM write data.
ram_rdata  in  9  RAM read data, valid one cycle after address.
h_sync_out  out  1  h_sync_in delayed 1 cycle.
v_sync_out  out  1  v_sync_in delayed 1 cycle.
rgb  out  12  pixel colour, aligned with delayed syncs.

Behaviour:
- Reset (async): state CLEAR, clear counter 0, bar_height 0, rgb 0, h_sync_out 1, v_sync_out 1, wr_ready 0, frame_done 0, ram_we 0, ram_addr 0, ram_wdata 0. Reset asserted mid-operation aborts everything and restarts CLEAR from bin 0.
- States: CLEAR -> WAIT_SYNC -> BLANK <-> DISPLAY.
- CLEAR:
  - ram_we 1, ram_wdata 0, ram_addr = counter 0..63, one bin per cycle (64 cycles).
  - Then WAIT_SYNC.
  - wr_ready 0; fetches suppressed; bar_height held 0.
- WAIT_SYNC: wr_ready 0; wait for (pixel_x==0, pixel_y==V_ACTIVE), then BLANK.
- BLANK:
  - Entered at (0, V_ACTIVE); frame_done pulses on the entry cycle.
  - wr_ready 1 combinationally. On a handshake: ram_we 1, ram_addr=wr_addr, ram_wdata=wr_data in the same cycle.
  - Exits to DISPLAY on the cycle pixel_y==V_TOTAL-1, pixel_x==H_TOTAL-2; wr_ready is 0 in that cycle.
- DISPLAY:
  - wr_ready 0, except when WAIT... WRITE_DURING_ACTIVE=1: wr_ready 1 in every non-fetch cycle.
  - Moves to BLANK at (0, V_ACTIVE).
- Fetch cycles (display read, absolute priority, ram_we 0):
  - pixel_x==H_TOTAL-2 and the next line is active (pixel_y<V_ACTIVE-1 or pixel_y==V_TOTAL-1): ram_addr 0.
  - pixel_y<V_ACTIVE, pixel_x<H_ACTIVE-BAR_WIDTH, pixel_x mod BAR_WIDTH==BAR_WIDTH-2: ram_addr = pixel_x/BAR_WIDTH+1.
- bar_height:
  - Loaded from min(ram_rdata, V_ACTIVE) on the edge ending the cycle after each fetch.
  - It therefore holds bin k throughout columns k*BAR_WIDTH..k*BAR_WIDTH+BAR_WIDTH-1.
- Pixel rule (registered, latency 1):
  - rgb = BAR_COLOR if video_on_in, pixel_x mod BAR_WIDTH != BAR_WIDTH-1, and pixel_y >= V_ACTIVE-bar_height.
  - Otherwise rgb = 0.
  - Column BAR_WIDTH-1 of each bar is the gap.
  - Height 0 means no lit pixel; height >= 480 lights the full column.
- Simultaneous write request and fetch: fetch wins, wr_ready 0, and the writer must hold wr_valid/addr/data.
- wr_valid with wr_ready 0: no RAM write occurs and the request stays pending with the writer.

Test Plan:
- Reset, then release -> ram_we high for exactly 64 cycles, addresses 0..63 with data 0; wr_ready 0 until pixel_y=480, pixel_x=0; frame_done pulses once there.
- In BLANK, write addr 3 = 100 -> ram_we/ram_addr 3/ram_wdata 100 same cycle. Next frame: rgb=0x0F0 at columns 30..38 for pixel_y 380..479, 0 at column 39 and at pixel_y 379.
- Write addr 5 = 500 -> bar 5 (columns 50..58) lit on all lines 0..479.
- WRITE_DURING_ACTIVE=0, wr_valid held during pixel_y=100 -> wr_ready 0 all line; write lands at (0,480).
- WRITE_DURING_ACTIVE=1, wr_valid at pixel_x=18, pixel_y=10 -> wr_ready 0, ram_addr 2 read; accepted at pixel_x=19.
- Assert reset at pixel_y=200 for 3 cycles -> rgb 0, syncs 1 immediately; CLEAR restarts at bin 0; all bars dark next frame.
